// File: rtl/dmem_responder.sv
// dmem_responder: memory-side slave for the core's data port.
// Word-organised SRAM with byte-lane stores, a programmable number of wait
// states, a pipeline stall output and a one-cycle bus error for accesses
// that fall outside [BASE_ADDR, BASE_ADDR + DEPTH*4).
//
// Handshake: the core raises req_mem with wmem/addr/wmask/wdata valid; a
// request seen while the responder is IDLE is accepted at that edge. The
// core must hold its pipeline while data_stall is high. The response
// (rdata for loads, data_err for out-of-range) is visible in the cycle after
// the access edge, which is the first cycle with data_stall low again.
`timescale 1ns/1ps

module dmem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_mem,
    input  logic        wmem,
    input  logic [3:0]  wmask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        data_err,
    output logic        data_stall
);

    localparam int unsigned AW = $clog2(DEPTH);

    // With two or more wait states the access is deferred to a later edge and
    // performed from captured request values; otherwise it happens at the
    // acceptance edge using the live inputs.
    localparam bit DEFERRED = (WAIT_STATES >= 2);

    // r_cnt holds the number of stall cycles still to come, including the
    // current one; the access fires in the WAIT cycle where it reads 1.
    localparam logic [3:0] CNT_INIT = DEFERRED ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    logic        r_cap_wmem;
    logic [3:0]  r_cap_wmask;
    logic [31:0] r_cap_addr;
    logic [31:0] r_cap_wdata;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;
    logic        r_err;

    logic          w_accept;
    logic          w_do_access;
    logic          w_acc_wmem;
    logic [3:0]    w_acc_wmask;
    logic [31:0]   w_acc_addr;
    logic [31:0]   w_acc_wdata;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic          w_unused;

    assign w_accept = (r_state == S_IDLE) && req_mem && !reset;

    // Select which request is performed this edge: captured (deferred) or live.
    always_comb begin
        w_do_access = 1'b0;
        w_acc_wmem  = 1'b0;
        w_acc_wmask = 4'h0;
        w_acc_addr  = 32'h0;
        w_acc_wdata = 32'h0;
        if (DEFERRED) begin
            w_do_access = !reset && (r_state == S_WAIT) && (r_cnt == 4'd1);
            w_acc_wmem  = r_cap_wmem;
            w_acc_wmask = r_cap_wmask;
            w_acc_addr  = r_cap_addr;
            w_acc_wdata = r_cap_wdata;
        end else begin
            w_do_access = w_accept;
            w_acc_wmem  = wmem;
            w_acc_wmask = wmask;
            w_acc_addr  = addr;
            w_acc_wdata = wdata;
        end
    end

    // BASE_ADDR is DEPTH*4-aligned, so the range test reduces to matching the
    // upper address bits and the word index is simply the middle bits.
    assign w_in_range = (w_acc_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign w_idx      = w_acc_addr[AW+1:2];

    // Byte offset bits are resolved by the core and deliberately ignored here.
    assign w_unused = ^w_acc_addr[1:0];

    // Stall: combinational on a fresh request, registered while waiting.
    assign data_stall = !reset &&
                        (((r_state == S_IDLE) && req_mem && (WAIT_STATES != 0)) ||
                         (r_state == S_WAIT));

    assign rdata    = r_rdata;
    assign data_err = r_err;

    // Next-state and wait counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req_mem && DEFERRED) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Capture the request at acceptance; only consumed while in WAIT.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_cap_wmem  <= wmem;
            r_cap_wmask <= wmask;
            r_cap_addr  <= addr;
            r_cap_wdata <= wdata;
        end
    end

    // SRAM byte-lane write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_do_access && w_acc_wmem && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_wmask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response registers: load data and one-cycle range error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_do_access) begin
                if (!w_in_range) begin
                    r_err <= 1'b1;
                    if (!w_acc_wmem) begin
                        r_rdata <= 32'h0;
                    end
                end else if (!w_acc_wmem) begin
                    r_rdata <= r_mem[w_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: four instances (0, 1, 2 and 5 wait
// states) share one stimulus bus; each section resets and checks only the
// instance it targets.
`timescale 1ns/1ps

module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_mem;
    logic        wmem;
    logic [3:0]  wmask;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] rd0, rd1, rd2, rd5;
    logic        er0, er1, er2, er5;
    logic        st0, st1, st2, st5;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .req_mem(req_mem), .wmem(wmem), .wmask(wmask),
        .addr(addr), .wdata(wdata), .rdata(rd0), .data_err(er0), .data_stall(st0)
    );
    dmem_responder #(.WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(reset), .req_mem(req_mem), .wmem(wmem), .wmask(wmask),
        .addr(addr), .wdata(wdata), .rdata(rd1), .data_err(er1), .data_stall(st1)
    );
    dmem_responder #(.WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset(reset), .req_mem(req_mem), .wmem(wmem), .wmask(wmask),
        .addr(addr), .wdata(wdata), .rdata(rd2), .data_err(er2), .data_stall(st2)
    );
    dmem_responder #(.WAIT_STATES(5)) u_ws5 (
        .clk(clk), .reset(reset), .req_mem(req_mem), .wmem(wmem), .wmask(wmask),
        .addr(addr), .wdata(wdata), .rdata(rd5), .data_err(er5), .data_stall(st5)
    );

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    function automatic logic [31:0] rd_of(input int ws);
        case (ws)
            0:       return rd0;
            1:       return rd1;
            2:       return rd2;
            default: return rd5;
        endcase
    endfunction

    function automatic logic er_of(input int ws);
        case (ws)
            0:       return er0;
            1:       return er1;
            2:       return er2;
            default: return er5;
        endcase
    endfunction

    function automatic logic st_of(input int ws);
        case (ws)
            0:       return st0;
            1:       return st1;
            2:       return st2;
            default: return st5;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset   = 1'b1;
        req_mem = 1'b0;
        cyc();
        reset   = 1'b0;
    endtask

    // One access against instance ws, starting in the current cycle (T0).
    // Checks stall high in T0..T(ws-1), no error while waiting, stall low in
    // T(ws); returns in T(ws) with req_mem low so the caller checks the response.
    task automatic acc(input int ws, input logic wm, input logic [31:0] a,
                       input logic [3:0] msk, input logic [31:0] d, input string tag);
        req_mem = 1'b1;
        wmem    = wm;
        addr    = a;
        wmask   = msk;
        wdata   = d;
        for (int k = 0; k < ws; k++) begin
            #1;
            chk({tag, "_stall_hi"}, 32'(st_of(ws)), 32'd1);
            if (k > 0) chk({tag, "_err_wait"}, 32'(er_of(ws)), 32'd0);
            cyc();
            req_mem = 1'b0;
            addr    = $urandom;
            wdata   = $urandom;
            wmask   = 4'($urandom);
            wmem    = 1'($urandom);
        end
        if (ws == 0) begin
            #1;
            chk({tag, "_stall_lo0"}, 32'(st_of(ws)), 32'd0);
            cyc();
            req_mem = 1'b0;
        end
        #1;
        chk({tag, "_stall_lo"}, 32'(st_of(ws)), 32'd0);
    endtask

    initial begin
        int ws_list[4];
        ws_list = '{0, 1, 2, 5};

        // Reset with a request pending: reset wins, stall forced low.
        reset   = 1'b1;
        req_mem = 1'b1;
        wmem    = 1'b0;
        wmask   = 4'h0;
        addr    = BASE;
        wdata   = 32'h0;
        cyc();
        cyc();
        #1;
        foreach (ws_list[j]) begin
            chk($sformatf("rst_stall_ws%0d", ws_list[j]), 32'(st_of(ws_list[j])), 32'd0);
            chk($sformatf("rst_rdata_ws%0d", ws_list[j]), rd_of(ws_list[j]), 32'd0);
            chk($sformatf("rst_err_ws%0d", ws_list[j]), 32'(er_of(ws_list[j])), 32'd0);
        end
        req_mem = 1'b0;
        reset   = 1'b0;
        cyc();

        // Full-word store then load, two wait states.
        acc(2, 1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, "t1_st");
        chk("t1_st_rdata_held", rd2, 32'h0);
        chk("t1_st_err", 32'(er2), 32'd0);
        acc(2, 1'b0, BASE + 32'h10, 4'h0, 32'h0, "t1_ld");
        chk("t1_ld_rdata", rd2, 32'hDEAD_BEEF);
        chk("t1_ld_err", 32'(er2), 32'd0);

        // Byte-lane stores and an empty mask.
        acc(2, 1'b1, BASE + 32'h20, 4'hF, 32'h1122_3344, "t2_pre");
        acc(2, 1'b1, BASE + 32'h20, 4'b0100, 32'h00AA_0000, "t2_lane");
        acc(2, 1'b0, BASE + 32'h20, 4'h0, 32'h0, "t2_ld1");
        chk("t2_lane_rdata", rd2, 32'h11AA_3344);
        acc(2, 1'b1, BASE + 32'h20, 4'h0, 32'hFFFF_FFFF, "t2_nomask");
        chk("t2_nomask_err", 32'(er2), 32'd0);
        acc(2, 1'b0, BASE + 32'h20, 4'h0, 32'h0, "t2_ld2");
        chk("t2_nomask_rdata", rd2, 32'h11AA_3344);

        // Out-of-range accesses on both sides of the window.
        acc(2, 1'b1, BASE, 4'hF, 32'hCAFE_0000, "t3_pre");
        acc(2, 1'b0, 32'h0000_FFFC, 4'h0, 32'h0, "t3_lo");
        chk("t3_lo_rdata", rd2, 32'h0);
        chk("t3_lo_err", 32'(er2), 32'd1);
        cyc();
        chk("t3_lo_err_pulse", 32'(er2), 32'd0);
        acc(2, 1'b0, BASE + 32'h10, 4'h0, 32'h0, "t3_ok1");
        chk("t3_ok1_rdata", rd2, 32'hDEAD_BEEF);
        acc(2, 1'b0, BASE + 32'h1000, 4'h0, 32'h0, "t3_hi");
        chk("t3_hi_rdata", rd2, 32'h0);
        chk("t3_hi_err", 32'(er2), 32'd1);
        acc(2, 1'b0, BASE + 32'h10, 4'h0, 32'h0, "t3_ok2");
        chk("t3_ok2_rdata", rd2, 32'hDEAD_BEEF);
        chk("t3_ok2_err", 32'(er2), 32'd0);
        acc(2, 1'b1, BASE + 32'h1000, 4'hF, 32'h1234_5678, "t3_hist");
        chk("t3_hist_err", 32'(er2), 32'd1);
        chk("t3_hist_rdata_held", rd2, 32'hDEAD_BEEF);
        acc(2, 1'b0, BASE, 4'h0, 32'h0, "t3_w0");
        chk("t3_w0_unchanged", rd2, 32'hCAFE_0000);

        // Request changes during WAIT are ignored; back-to-back acceptance in T2.
        acc(2, 1'b1, BASE + 32'h40, 4'hF, 32'h7777_7777, "t6_pre");
        req_mem = 1'b1;
        wmem    = 1'b1;
        addr    = BASE + 32'h30;
        wmask   = 4'hF;
        wdata   = 32'h5555_5555;
        #1;
        chk("t6_t0_stall", 32'(st2), 32'd1);
        cyc();
        addr  = BASE + 32'h40;
        wdata = 32'h6666_6666;
        #1;
        chk("t6_t1_stall", 32'(st2), 32'd1);
        cyc();
        wmem = 1'b0;
        addr = BASE + 32'h30;
        #1;
        chk("t6_reaccept_stall", 32'(st2), 32'd1);
        cyc();
        req_mem = 1'b0;
        #1;
        chk("t6_t3_stall", 32'(st2), 32'd1);
        cyc();
        chk("t6_t4_stall", 32'(st2), 32'd0);
        chk("t6_captured_data", rd2, 32'h5555_5555);
        acc(2, 1'b0, BASE + 32'h40, 4'h0, 32'h0, "t6_other");
        chk("t6_other_untouched", rd2, 32'h7777_7777);

        // One wait state: access at the acceptance edge.
        reset_pulse();
        acc(1, 1'b1, BASE + 32'h50, 4'hF, 32'h0F0F_0F0F, "ws1_st");
        acc(1, 1'b0, BASE + 32'h50, 4'h0, 32'h0, "ws1_ld");
        chk("ws1_rdata", rd1, 32'h0F0F_0F0F);
        chk("ws1_err", 32'(er1), 32'd0);

        // Zero wait states: one access per cycle, never stalls.
        reset_pulse();
        for (int i = 0; i < 8; i++) begin
            req_mem = 1'b1;
            wmem    = 1'b1;
            wmask   = 4'hF;
            addr    = BASE + 32'(4 * i);
            wdata   = 32'(i) * 32'h0101_0101;
            #1;
            chk($sformatf("t4_st%0d_stall", i), 32'(st0), 32'd0);
            cyc();
        end
        for (int i = 0; i < 8; i++) begin
            req_mem = 1'b1;
            wmem    = 1'b0;
            addr    = BASE + 32'(4 * i);
            #1;
            chk($sformatf("t4_ld%0d_stall", i), 32'(st0), 32'd0);
            chk($sformatf("t4_ld%0d_err", i), 32'(er0), 32'd0);
            if (i > 0) chk($sformatf("t4_rd%0d", i - 1), rd0, 32'(i - 1) * 32'h0101_0101);
            cyc();
        end
        req_mem = 1'b0;
        #1;
        chk("t4_rd7", rd0, 32'h0707_0707);

        // Reset in the middle of a five-wait-state store drops the write.
        reset_pulse();
        acc(5, 1'b1, BASE, 4'hF, 32'hA5A5_A5A5, "t5_pre");
        acc(5, 1'b0, BASE, 4'h0, 32'h0, "t5_ld0");
        chk("t5_ld0_rdata", rd5, 32'hA5A5_A5A5);
        req_mem = 1'b1;
        wmem    = 1'b1;
        addr    = BASE;
        wmask   = 4'hF;
        wdata   = 32'h5A5A_5A5A;
        #1;
        chk("t5_t0_stall", 32'(st5), 32'd1);
        cyc();
        req_mem = 1'b0;
        #1;
        chk("t5_t1_stall", 32'(st5), 32'd1);
        cyc();
        reset = 1'b1;
        #1;
        chk("t5_stall_forced", 32'(st5), 32'd0);
        cyc();
        reset = 1'b0;
        #1;
        chk("t5_after_stall", 32'(st5), 32'd0);
        chk("t5_after_rdata", rd5, 32'h0);
        chk("t5_after_err", 32'(er5), 32'd0);
        chk("t5_after_state", 32'(u_ws5.r_state), 32'd0);
        acc(5, 1'b0, BASE, 4'h0, 32'h0, "t5_ld1");
        chk("t5_write_dropped", rd5, 32'hA5A5_A5A5);

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
